data_path_gen: RTL and testbench
================================

# data_path_gen

Parametrised successor to the team's 8-bit computer data path. It replaces the fixed A/B accumulator pair with an NREG-entry register file, widens all datapath registers to DATA_W, and adds a stack pointer with increment/decrement and add-with-carry through the CCR. It sits between the control-unit FSM, which drives all `*_Sel` and `*_Load` strobes, and the memory, which is addressed by MAR.

## Interface
- `DATA_W`, default 8: width of data, address, PC, SP, MAR, IR and registers (≥4).
- `NREG`, default 4: number of general registers; power of 2, ≥2. `RSEL_W = $clog2(NREG)`.
- `RST_PC`, default 0: PC value after reset.
- `RST_SP`, default all ones: SP value after reset.

Ports (name, direction, width, meaning):
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `from_memory` in DATA_W: memory read data.
- `ALU_Sel` in 3: ALU operation.
- `Bus1_Sel` in 2: 00 PC, 01 Reg[Rs1_Sel], 10 SP, 11 zero.
- `Bus2_Sel` in 2: 00 ALU_Result, 01 Bus1, 10 from_memory, 11 Reg[Rs2_Sel].
- `Rd_Sel`, `Rs1_Sel`, `Rs2_Sel` in RSEL_W: register write and read selects.
- `IR_Load`, `MAR_Load`, `PC_Load`, `Reg_Load`, `CCR_Load` in 1: load strobes. Each captures Bus2; CCR_Load captures the ALU flags.
- `PC_Inc`, `SP_Inc`, `SP_Dec` in 1: counter strobes.
- `address` out DATA_W: MAR.
- `to_memory` out DATA_W: Bus1, combinational.
- `IR_out` out DATA_W: IR.
- `CCR_Result` out 4: CCR as NZVC, bit 3 = N.

## Operation
- ALU operands: X = Bus1, Y = Reg[Rs2_Sel]. Result is DATA_W bits.
- ALU operations by `ALU_Sel`:
  - 000 ADD X+Y
  - 001 SUB X−Y
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 INC X
  - 110 DEC X
  - 111 ADC X+Y+CCR.C (uses the registered C)
- Flags:
  - N = result MSB.
  - Z = (result == 0).
  - V = two's-complement overflow for arithmetic ops; 0 for logic ops.
  - C = carry-out for ADD/ADC/INC; borrow for SUB/DEC (1 when X < subtrahend, unsigned); 0 for logic ops.
- Register file: Reg_Load writes Bus2 into Reg[Rd_Sel]. There is no hardwired-zero register. A read in the same cycle as a write to the same index returns the old value (no bypass).
- PC:
  - PC_Load takes priority over PC_Inc.
  - PC_Inc wraps from all ones to 0.
- SP:
  - SP_Inc alone gives +1; SP_Dec alone gives −1. Both wrap.
  - SP_Inc and SP_Dec together leave SP unchanged.
- Loads are independent. Any combination may be asserted in one cycle, and all sample the same pre-edge Bus2 and flags.
- Reset overrides every strobe in the same cycle. It sets PC=RST_PC, SP=RST_SP, MAR=0, IR=0, CCR=0000, and all registers 0.

## Timing
- All state updates on the rising `Clk` edge.
- One-cycle latency from strobe to the visible register value.
- `address`, `IR_out` and `CCR_Result` are registered.
- `to_memory` follows Bus1 combinationally in the same cycle as the selects change.
- CCR_Result reflects flags computed in the cycle CCR_Load was high, visible from the next edge.
- ADC uses the CCR value that existed before the edge. Back-to-back ADC with CCR_Load therefore chains the carry each cycle.
- Reset is effective at the first rising edge where it is high. Outputs hold their reset values while Reset stays high. Normal operation resumes on the first edge after Reset falls.
- Reset asserted mid-sequence discards any in-flight strobes for that cycle.

## Test plan
- **Reset:** Reset high for 2 cycles with all strobes high and from_memory=AA → PC=00, SP=FF, MAR=00, IR=00, CCR_Result=0000, Reg[0..3]=00.
- **ADD overflow:**
  - Load R1=7F and R2=01 from memory (Bus2_Sel=10, Reg_Load).
  - Then Bus1_Sel=01 Rs1=1, Rs2=2, ALU_Sel=000, Bus2_Sel=00, Rd=3, Reg_Load, CCR_Load.
  - → R3=80, CCR_Result=1010.
- **SUB then ADC chain:**
  - R1=00, R2=01, SUB → result FF, CCR=1001.
  - Then R1=FF, ADC → 01, CCR=0001.
- **PC:**
  - PC_Load with from_memory=FF → PC=FF.
  - PC_Inc → 00.
  - PC_Load and PC_Inc together with from_memory=10 → PC=10.
  - MAR_Load with Bus2_Sel=01, Bus1_Sel=00 → address=10.
- **SP:**
  - After reset (FF), SP_Inc → 00.
  - SP_Dec twice → FE.
  - SP_Inc and SP_Dec together → FE.
- **Read-during-write and width:**
  - Reg_Load Rd=1 with Rs2=1 in the same cycle → ALU sees the old R1.
  - Reset asserted in the same cycle as Reg_Load and CCR_Load → reset values.
  - DATA_W=16 instance: 7FFF+0001 → 8000, CCR=1010.

Source files
------------

// File: rtl/data_path_gen_if.sv
// Control-unit / memory side of the parametrised data path: select and load strobes in,
// MAR, IR, CCR and Bus1 out.
interface data_path_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4
);
    localparam int unsigned RSEL_W = $clog2(NREG);

    logic [DATA_W-1:0] from_memory;
    logic [2:0]        ALU_Sel;
    logic [1:0]        Bus1_Sel;
    logic [1:0]        Bus2_Sel;
    logic [RSEL_W-1:0] Rd_Sel;
    logic [RSEL_W-1:0] Rs1_Sel;
    logic [RSEL_W-1:0] Rs2_Sel;
    logic              IR_Load;
    logic              MAR_Load;
    logic              PC_Load;
    logic              Reg_Load;
    logic              CCR_Load;
    logic              PC_Inc;
    logic              SP_Inc;
    logic              SP_Dec;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] to_memory;
    logic [DATA_W-1:0] IR_out;
    logic [3:0]        CCR_Result;

    modport master (
        output from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel, Rd_Sel, Rs1_Sel, Rs2_Sel,
               IR_Load, MAR_Load, PC_Load, Reg_Load, CCR_Load, PC_Inc, SP_Inc, SP_Dec,
        input  address, to_memory, IR_out, CCR_Result
    );

    modport slave (
        input  from_memory, ALU_Sel, Bus1_Sel, Bus2_Sel, Rd_Sel, Rs1_Sel, Rs2_Sel,
               IR_Load, MAR_Load, PC_Load, Reg_Load, CCR_Load, PC_Inc, SP_Inc, SP_Dec,
        output address, to_memory, IR_out, CCR_Result
    );
endinterface

// File: rtl/data_path_gen.sv
// Parametrised data path: NREG-entry register file, PC, SP, MAR, IR, NZVC CCR and an
// 8-function ALU joined by two buses.
module data_path_gen #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       NREG   = 4,
    parameter logic [DATA_W-1:0] RST_PC = '0,
    parameter logic [DATA_W-1:0] RST_SP = '1
) (
    input  logic            Clk,
    input  logic            Reset,
    data_path_gen_if.slave  bus
);
    localparam int unsigned MSB   = DATA_W - 1;
    localparam int unsigned EXT_W = DATA_W + 1;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_INC = 3'b101;
    localparam logic [2:0] ALU_DEC = 3'b110;
    localparam logic [2:0] ALU_ADC = 3'b111;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_sp;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [3:0]        r_ccr;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [DATA_W-1:0] w_bus1;
    logic [DATA_W-1:0] w_bus2;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_n;
    logic              w_z;
    logic              w_v;
    logic              w_c;

    always_comb begin
        w_bus1 = '0;
        case (bus.Bus1_Sel)
            2'b00:   w_bus1 = r_pc;
            2'b01:   w_bus1 = r_regs[bus.Rs1_Sel];
            2'b10:   w_bus1 = r_sp;
            default: w_bus1 = '0;
        endcase
    end

    assign w_x = w_bus1;
    assign w_y = r_regs[bus.Rs2_Sel];

    // Result computed one bit wide so bit DATA_W is carry-out (add) or borrow (subtract).
    always_comb begin
        w_ext = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (bus.ALU_Sel)
            ALU_ADD: begin
                w_ext = {1'b0, w_x} + {1'b0, w_y};
                w_c   = w_ext[DATA_W];
                w_v   = (w_x[MSB] == w_y[MSB]) && (w_ext[MSB] != w_x[MSB]);
            end
            ALU_SUB: begin
                w_ext = {1'b0, w_x} - {1'b0, w_y};
                w_c   = w_ext[DATA_W];
                w_v   = (w_x[MSB] != w_y[MSB]) && (w_ext[MSB] != w_x[MSB]);
            end
            ALU_AND: w_ext = {1'b0, w_x & w_y};
            ALU_OR:  w_ext = {1'b0, w_x | w_y};
            ALU_XOR: w_ext = {1'b0, w_x ^ w_y};
            ALU_INC: begin
                w_ext = {1'b0, w_x} + EXT_W'(1);
                w_c   = w_ext[DATA_W];
                w_v   = !w_x[MSB] && w_ext[MSB];
            end
            ALU_DEC: begin
                w_ext = {1'b0, w_x} - EXT_W'(1);
                w_c   = w_ext[DATA_W];
                w_v   = w_x[MSB] && !w_ext[MSB];
            end
            ALU_ADC: begin
                w_ext = {1'b0, w_x} + {1'b0, w_y} + EXT_W'(r_ccr[0]);
                w_c   = w_ext[DATA_W];
                w_v   = (w_x[MSB] == w_y[MSB]) && (w_ext[MSB] != w_x[MSB]);
            end
            default: w_ext = '0;
        endcase
    end

    assign w_alu_result = w_ext[DATA_W-1:0];
    assign w_n          = w_alu_result[MSB];
    assign w_z          = (w_alu_result == '0);

    always_comb begin
        w_bus2 = '0;
        case (bus.Bus2_Sel)
            2'b00:   w_bus2 = w_alu_result;
            2'b01:   w_bus2 = w_bus1;
            2'b10:   w_bus2 = bus.from_memory;
            default: w_bus2 = r_regs[bus.Rs2_Sel];
        endcase
    end

    // All loads sample the same pre-edge Bus2 and flags; reset discards every strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc  <= RST_PC;
            r_sp  <= RST_SP;
            r_mar <= '0;
            r_ir  <= '0;
            r_ccr <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (bus.IR_Load)  r_ir  <= w_bus2;
            if (bus.MAR_Load) r_mar <= w_bus2;
            if (bus.CCR_Load) r_ccr <= {w_n, w_z, w_v, w_c};
            if (bus.Reg_Load) r_regs[bus.Rd_Sel] <= w_bus2;

            if (bus.PC_Load)     r_pc <= w_bus2;
            else if (bus.PC_Inc) r_pc <= r_pc + DATA_W'(1);

            if (bus.SP_Inc && !bus.SP_Dec)      r_sp <= r_sp + DATA_W'(1);
            else if (bus.SP_Dec && !bus.SP_Inc) r_sp <= r_sp - DATA_W'(1);
        end
    end

    assign bus.address    = r_mar;
    assign bus.IR_out     = r_ir;
    assign bus.CCR_Result = r_ccr;
    assign bus.to_memory  = w_bus1;
endmodule

// File: tb/tb_data_path_gen.sv
// Scoreboard bench for data_path_gen: 8-bit and 16-bit instances share clock and reset;
// PC, SP and registers are observed through to_memory by steering Bus1.
module tb_data_path_gen;
    localparam int unsigned K_PC   = 0;
    localparam int unsigned K_SP   = 1;
    localparam int unsigned K_REG  = 2;
    localparam int unsigned K_ADDR = 3;
    localparam int unsigned K_IR   = 4;
    localparam int unsigned K_CCR  = 5;

    typedef struct {
        string       tag;
        int unsigned dut;
        int unsigned kind;
        int unsigned idx;
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        logic [1:0] b1;
        logic [2:0] op;
        logic [7:0] res;
        logic [3:0] ccr;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    exp_t        sb[$];

    // R1 = C3, R2 = 5A unless Bus1 selects zero; each result lands in R3
    op_t ops [10] = '{
        '{2'b01, 3'b000, 8'h1D, 4'b0001},
        '{2'b01, 3'b001, 8'h69, 4'b0010},
        '{2'b01, 3'b010, 8'h42, 4'b0000},
        '{2'b01, 3'b011, 8'hDB, 4'b1000},
        '{2'b01, 3'b100, 8'h99, 4'b1000},
        '{2'b01, 3'b101, 8'hC4, 4'b1000},
        '{2'b01, 3'b110, 8'hC2, 4'b1000},
        '{2'b11, 3'b110, 8'hFF, 4'b1001},
        '{2'b11, 3'b111, 8'h5B, 4'b0000},
        '{2'b11, 3'b010, 8'h00, 4'b0100}
    };

    data_path_gen_if #(.DATA_W(8),  .NREG(4)) if8 ();
    data_path_gen_if #(.DATA_W(16), .NREG(4)) if16 ();

    data_path_gen #(.DATA_W(8), .NREG(4), .RST_PC(8'h00), .RST_SP(8'hFF)) u_dut8 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (if8)
    );

    data_path_gen #(.DATA_W(16), .NREG(4), .RST_PC(16'h0000), .RST_SP(16'hFFFF)) u_dut16 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (if16)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input string tag, input int unsigned dut, input int unsigned kind,
                        input int unsigned idx, input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic idle();
        if8.from_memory = '0; if8.ALU_Sel = '0; if8.Bus1_Sel = '0; if8.Bus2_Sel = '0;
        if8.Rd_Sel = '0; if8.Rs1_Sel = '0; if8.Rs2_Sel = '0;
        if8.IR_Load = 0; if8.MAR_Load = 0; if8.PC_Load = 0; if8.Reg_Load = 0;
        if8.CCR_Load = 0; if8.PC_Inc = 0; if8.SP_Inc = 0; if8.SP_Dec = 0;
        if16.from_memory = '0; if16.ALU_Sel = '0; if16.Bus1_Sel = '0; if16.Bus2_Sel = '0;
        if16.Rd_Sel = '0; if16.Rs1_Sel = '0; if16.Rs2_Sel = '0;
        if16.IR_Load = 0; if16.MAR_Load = 0; if16.PC_Load = 0; if16.Reg_Load = 0;
        if16.CCR_Load = 0; if16.PC_Inc = 0; if16.SP_Inc = 0; if16.SP_Dec = 0;
    endtask

    task automatic observe(input exp_t e, output logic [15:0] got);
        if (e.dut == 0) begin
            case (e.kind)
                K_PC:    if8.Bus1_Sel = 2'b00;
                K_SP:    if8.Bus1_Sel = 2'b10;
                K_REG:   begin if8.Bus1_Sel = 2'b01; if8.Rs1_Sel = 2'(e.idx); end
                default: ;
            endcase
            #1;
            case (e.kind)
                K_ADDR:  got = 16'(if8.address);
                K_IR:    got = 16'(if8.IR_out);
                K_CCR:   got = 16'(if8.CCR_Result);
                default: got = 16'(if8.to_memory);
            endcase
        end else begin
            case (e.kind)
                K_PC:    if16.Bus1_Sel = 2'b00;
                K_SP:    if16.Bus1_Sel = 2'b10;
                K_REG:   begin if16.Bus1_Sel = 2'b01; if16.Rs1_Sel = 2'(e.idx); end
                default: ;
            endcase
            #1;
            case (e.kind)
                K_ADDR:  got = if16.address;
                K_IR:    got = if16.IR_out;
                K_CCR:   got = 16'(if16.CCR_Result);
                default: got = if16.to_memory;
            endcase
        end
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e, got);
            check_eq(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        drain();
    endtask

    task automatic load8(input logic [1:0] rd, input logic [7:0] val);
        if8.from_memory = val; if8.Bus2_Sel = 2'b10; if8.Rd_Sel = rd; if8.Reg_Load = 1;
        push($sformatf("load8_r%0d", rd), 0, K_REG, int'(rd), 16'(val));
        tick();
    endtask

    task automatic load16(input logic [1:0] rd, input logic [15:0] val);
        if16.from_memory = val; if16.Bus2_Sel = 2'b10; if16.Rd_Sel = rd; if16.Reg_Load = 1;
        push($sformatf("load16_r%0d", rd), 1, K_REG, int'(rd), val);
        tick();
    endtask

    task automatic alu8(input string tag, input logic [1:0] b1, input logic [1:0] rs1,
                        input logic [2:0] op, input logic [1:0] rd,
                        input logic [7:0] er, input logic [3:0] ec);
        if8.Bus1_Sel = b1; if8.Rs1_Sel = rs1; if8.Rs2_Sel = 2'd2; if8.ALU_Sel = op;
        if8.Bus2_Sel = 2'b00; if8.Rd_Sel = rd; if8.Reg_Load = 1; if8.CCR_Load = 1;
        push({tag, "_res"}, 0, K_REG, int'(rd), 16'(er));
        push({tag, "_ccr"}, 0, K_CCR, 0, 16'(ec));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        // Reset with every strobe active and memory data AA
        rst = 1'b1;
        if8.from_memory = 8'hAA; if8.Bus2_Sel = 2'b10;
        if8.IR_Load = 1; if8.MAR_Load = 1; if8.PC_Load = 1; if8.Reg_Load = 1;
        if8.CCR_Load = 1; if8.PC_Inc = 1; if8.SP_Inc = 1; if8.SP_Dec = 1;
        if16.from_memory = 16'hAAAA; if16.Bus2_Sel = 2'b10; if16.PC_Load = 1; if16.Reg_Load = 1;
        push("rst_pc", 0, K_PC, 0, 16'h00);
        push("rst_sp", 0, K_SP, 0, 16'hFF);
        push("rst_mar", 0, K_ADDR, 0, 16'h00);
        push("rst_ir", 0, K_IR, 0, 16'h00);
        push("rst_ccr", 0, K_CCR, 0, 16'h0);
        for (int i = 0; i < 4; i++) push($sformatf("rst_r%0d", i), 0, K_REG, i, 16'h00);
        push("rst16_pc", 1, K_PC, 0, 16'h0000);
        push("rst16_sp", 1, K_SP, 0, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        idle();
        drain();
        rst = 1'b0;

        // ADD overflow 7F + 01
        load8(2'd1, 8'h7F);
        load8(2'd2, 8'h01);
        if8.Bus1_Sel = 2'b01; if8.Rs1_Sel = 2'd1;
        #1;
        check_eq("to_mem_comb", 16'(if8.to_memory), 16'h7F);
        alu8("add_ovf", 2'b01, 2'd1, 3'b000, 2'd3, 8'h80, 4'b1010);

        // SUB borrow, then ADC chaining the registered carry
        load8(2'd1, 8'h00);
        alu8("sub", 2'b01, 2'd1, 3'b001, 2'd0, 8'hFF, 4'b1001);
        load8(2'd1, 8'hFF);
        alu8("adc1", 2'b01, 2'd1, 3'b111, 2'd0, 8'h01, 4'b0001);
        alu8("adc2", 2'b01, 2'd0, 3'b111, 2'd0, 8'h03, 4'b0000);

        // Every ALU function with flag patterns
        load8(2'd1, 8'hC3);
        load8(2'd2, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            alu8($sformatf("op%0d", i), ops[i].b1, 2'd1, ops[i].op, 2'd3, ops[i].res, ops[i].ccr);
        end

        // PC load/inc/priority, MAR from Bus1, IR load
        if8.from_memory = 8'hFF; if8.Bus2_Sel = 2'b10; if8.PC_Load = 1;
        push("pc_load", 0, K_PC, 0, 16'hFF);
        tick();
        if8.PC_Inc = 1;
        push("pc_wrap", 0, K_PC, 0, 16'h00);
        tick();
        if8.from_memory = 8'h10; if8.Bus2_Sel = 2'b10; if8.PC_Load = 1; if8.PC_Inc = 1;
        push("pc_prio", 0, K_PC, 0, 16'h10);
        tick();
        if8.Bus1_Sel = 2'b00; if8.Bus2_Sel = 2'b01; if8.MAR_Load = 1;
        push("mar_pc", 0, K_ADDR, 0, 16'h10);
        tick();
        if8.from_memory = 8'hA5; if8.Bus2_Sel = 2'b10; if8.IR_Load = 1; if8.MAR_Load = 1;
        push("ir_load", 0, K_IR, 0, 16'hA5);
        push("mar_mem", 0, K_ADDR, 0, 16'hA5);
        tick();

        // SP wrap and simultaneous inc/dec
        if8.SP_Inc = 1;
        push("sp_inc_wrap", 0, K_SP, 0, 16'h00);
        tick();
        if8.SP_Dec = 1;
        push("sp_dec_wrap", 0, K_SP, 0, 16'hFF);
        tick();
        if8.SP_Dec = 1;
        push("sp_dec", 0, K_SP, 0, 16'hFE);
        tick();
        if8.SP_Inc = 1; if8.SP_Dec = 1;
        push("sp_both", 0, K_SP, 0, 16'hFE);
        tick();

        // Write R1 while the ALU reads R1 through Rs2: ALU must see the old C3
        if8.Bus1_Sel = 2'b11; if8.Rs2_Sel = 2'd1; if8.ALU_Sel = 3'b000; if8.CCR_Load = 1;
        if8.from_memory = 8'h11; if8.Bus2_Sel = 2'b10; if8.Rd_Sel = 2'd1; if8.Reg_Load = 1;
        push("rdw_ccr", 0, K_CCR, 0, 16'h8);
        push("rdw_r1", 0, K_REG, 1, 16'h11);
        tick();

        // Reset mid-sequence discards the in-flight strobes
        rst = 1'b1;
        if8.from_memory = 8'h77; if8.Bus2_Sel = 2'b10; if8.Rd_Sel = 2'd2; if8.Reg_Load = 1;
        if8.CCR_Load = 1; if8.ALU_Sel = 3'b110; if8.Bus1_Sel = 2'b11;
        if8.PC_Inc = 1; if8.SP_Dec = 1; if8.IR_Load = 1; if8.MAR_Load = 1;
        push("mid_rst_r2", 0, K_REG, 2, 16'h00);
        push("mid_rst_ccr", 0, K_CCR, 0, 16'h0);
        push("mid_rst_pc", 0, K_PC, 0, 16'h00);
        push("mid_rst_sp", 0, K_SP, 0, 16'hFF);
        push("mid_rst_ir", 0, K_IR, 0, 16'h00);
        tick();
        rst = 1'b0;
        if8.PC_Inc = 1;
        push("post_rst_pc", 0, K_PC, 0, 16'h01);
        tick();

        // 16-bit instance: 7FFF + 0001
        load16(2'd1, 16'h7FFF);
        load16(2'd2, 16'h0001);
        if16.Bus1_Sel = 2'b01; if16.Rs1_Sel = 2'd1; if16.Rs2_Sel = 2'd2; if16.ALU_Sel = 3'b000;
        if16.Bus2_Sel = 2'b00; if16.Rd_Sel = 2'd3; if16.Reg_Load = 1; if16.CCR_Load = 1;
        push("w16_res", 1, K_REG, 3, 16'h8000);
        push("w16_ccr", 1, K_CCR, 0, 16'hA);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
